// File: rtl/dual_issue_scheduler.sv
// Dual-issue stage: registers decoded pairs onto lanes 0/1. A pair is split across two issue
// cycles on a cross-lane load-use hazard or a memory-port conflict.
module dual_issue_scheduler #(
  parameter int unsigned INSN_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_v1,
  input  logic [INSN_W-1:0] in_insn0,
  input  logic [INSN_W-1:0] in_insn1,
  input  logic [4:0]        in_rd0,
  input  logic [4:0]        in_rs1_1,
  input  logic [4:0]        in_rs2_1,
  input  logic              in_mrd0,
  input  logic              in_mrd1,
  input  logic              in_mwr0,
  input  logic              in_mwr1,
  input  logic              iss_ready,
  output logic              iss0_valid,
  output logic [INSN_W-1:0] iss0_insn,
  output logic              iss1_valid,
  output logic [INSN_W-1:0] iss1_insn,
  output logic [CNT_W-1:0]  split_count
);

  typedef enum logic [0:0] {StIssue, StHold} state_e;

  state_e              state_q, state_d;
  logic                iss0_valid_q, iss0_valid_d;
  logic                iss1_valid_q, iss1_valid_d;
  logic [INSN_W-1:0]   iss0_insn_q, iss0_insn_d;
  logic [INSN_W-1:0]   iss1_insn_q, iss1_insn_d;
  logic [INSN_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic adv, accept, hz_ld, hz_mem, split;

  // Output register may load when empty or when execute takes its contents.
  assign adv      = !(iss0_valid_q | iss1_valid_q) | iss_ready;
  assign in_ready = (state_q == StIssue) & adv & !flush;
  assign accept   = in_valid & in_ready;

  assign hz_ld  = in_mrd0 & (in_rd0 != 5'd0) & ((in_rd0 == in_rs1_1) | (in_rd0 == in_rs2_1));
  assign hz_mem = (in_mrd0 | in_mwr0) & (in_mrd1 | in_mwr1);
  assign split  = in_v1 & (hz_ld | hz_mem);

  always_comb begin
    state_d      = state_q;
    iss0_valid_d = iss0_valid_q;
    iss1_valid_d = iss1_valid_q;
    iss0_insn_d  = iss0_insn_q;
    iss1_insn_d  = iss1_insn_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    if (flush) begin
      state_d      = StIssue;
      iss0_valid_d = 1'b0;
      iss1_valid_d = 1'b0;
      hold_d       = '0;
    end else if (adv) begin
      unique case (state_q)
        StIssue: begin
          if (accept) begin
            iss0_valid_d = 1'b1;
            iss0_insn_d  = in_insn0;
            if (split) begin
              iss1_valid_d = 1'b0;
              hold_d       = in_insn1;
              state_d      = StHold;
              if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
              iss1_valid_d = in_v1;
              iss1_insn_d  = in_insn1;
            end
          end else begin
            iss0_valid_d = 1'b0;
            iss1_valid_d = 1'b0;
          end
        end
        StHold: begin
          // Held slot-1 instruction goes out alone on lane 0.
          iss0_valid_d = 1'b1;
          iss0_insn_d  = hold_q;
          iss1_valid_d = 1'b0;
          state_d      = StIssue;
        end
        default: state_d = StIssue;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIssue;
      iss0_valid_q <= 1'b0;
      iss1_valid_q <= 1'b0;
      iss0_insn_q  <= '0;
      iss1_insn_q  <= '0;
      hold_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      iss0_valid_q <= iss0_valid_d;
      iss1_valid_q <= iss1_valid_d;
      iss0_insn_q  <= iss0_insn_d;
      iss1_insn_q  <= iss1_insn_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
    end
  end

  assign iss0_valid  = iss0_valid_q;
  assign iss1_valid  = iss1_valid_q;
  assign iss0_insn   = iss0_insn_q;
  assign iss1_insn   = iss1_insn_q;
  assign split_count = cnt_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler (CNT_W=4 build): stimulus pushes expected issues,
// a negedge monitor pops and compares on every lane-0 handshake.
module tb_dual_issue_scheduler;
  localparam int unsigned INSN_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic in_v1 = 1'b0;
  logic [INSN_W-1:0] in_insn0 = '0, in_insn1 = '0;
  logic [4:0] in_rd0 = '0, in_rs1_1 = '0, in_rs2_1 = '0;
  logic in_mrd0 = 1'b0, in_mrd1 = 1'b0, in_mwr0 = 1'b0, in_mwr1 = 1'b0;
  logic iss_ready = 1'b1;
  logic iss0_valid, iss1_valid;
  logic [INSN_W-1:0] iss0_insn, iss1_insn;
  logic [CNT_W-1:0] split_count;

  dual_issue_scheduler #(.INSN_W(INSN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_v1(in_v1), .in_insn0(in_insn0), .in_insn1(in_insn1), .in_rd0(in_rd0),
    .in_rs1_1(in_rs1_1), .in_rs2_1(in_rs2_1), .in_mrd0(in_mrd0), .in_mrd1(in_mrd1),
    .in_mwr0(in_mwr0), .in_mwr1(in_mwr1), .iss_ready(iss_ready), .iss0_valid(iss0_valid),
    .iss0_insn(iss0_insn), .iss1_valid(iss1_valid), .iss1_insn(iss1_insn),
    .split_count(split_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              v1;
    logic [INSN_W-1:0] i0;
    logic [INSN_W-1:0] i1;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every lane-0 handshake must match the oldest expected issue.
  always @(negedge clk) begin
    if (rst_n && iss_ready && (iss0_valid || iss1_valid)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue: unexpected v0=%0b i0=%h v1=%0b i1=%h", iss0_valid, iss0_insn,
                 iss1_valid, iss1_insn);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (iss0_valid !== 1'b1 || iss0_insn !== e.i0 || iss1_valid !== e.v1 ||
            (e.v1 && iss1_insn !== e.i1)) begin
          bad++;
          $display("FAIL issue: got v0=%0b i0=%h v1=%0b i1=%h want v0=1 i0=%h v1=%0b i1=%h",
                   iss0_valid, iss0_insn, iss1_valid, iss1_insn, e.i0, e.v1, e.i1);
        end
      end
    end
  end

  // Drive one pair, wait (bounded) for acceptance, push the expected issue(s).
  task automatic send_pair(input logic v1, input logic [INSN_W-1:0] i0, input logic [INSN_W-1:0] i1,
                           input logic [4:0] rd0, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic mrd0, input logic mwr0, input logic mrd1, input logic mwr1,
                           input logic exp_split);
    int n = 0;
    in_valid = 1'b1; in_v1 = v1; in_insn0 = i0; in_insn1 = i1;
    in_rd0 = rd0; in_rs1_1 = rs1; in_rs2_1 = rs2;
    in_mrd0 = mrd0; in_mwr0 = mwr0; in_mrd1 = mrd1; in_mwr1 = mwr1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout: in_ready stuck at 0 want 1");
        break;
      end
    end
    if (n <= 50) begin
      if (exp_split) begin
        exp_q.push_back('{v1: 1'b0, i0: i0, i1: '0});
        exp_q.push_back('{v1: 1'b0, i0: i1, i1: '0});
      end else begin
        exp_q.push_back('{v1: v1, i0: i0, i1: i1});
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("reset_iss0_valid", 64'(iss0_valid), 64'd0);
    check("reset_iss1_valid", 64'(iss1_valid), 64'd0);
    check("reset_iss0_insn", 64'(iss0_insn), 64'd0);
    check("reset_split_count", 64'(split_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // T1: add x5,x1,x2 / sub x6,x7,x8 dual issue.
    send_pair(1, 32'h0020_82b3, 32'h4083_8333, 5, 7, 8, 0, 0, 0, 0, 0);
    check("t1_split_count", 64'(split_count), 64'd0);
    idle(2);

    // T2: lw x5 / add x6,x5,x1 splits; scheduler busy for one cycle.
    send_pair(1, 32'h0000_a283, 32'h0012_8333, 5, 5, 1, 1, 0, 0, 0, 1);
    @(negedge clk);
    check("t2_in_ready_hold", 64'(in_ready), 64'd0);
    check("t2_iss1_valid", 64'(iss1_valid), 64'd0);
    check("t2_split_count", 64'(split_count), 64'd1);
    idle(3);

    // T3: lw x0 / add x6,x0,x1 no split; in_v1=0 never splits; sw / lw splits.
    send_pair(1, 32'h0000_a003, 32'h0010_0333, 0, 0, 1, 1, 0, 0, 0, 0);
    send_pair(0, 32'h0000_a283, 32'hdead_beef, 5, 5, 5, 1, 0, 0, 0, 0);
    check("t3_no_split_count", 64'(split_count), 64'd1);
    send_pair(1, 32'h0051_2023, 32'h0001_a383, 9, 3, 0, 0, 1, 1, 0, 1);
    check("t3_mem_split_count", 64'(split_count), 64'd2);
    idle(3);

    // T4: execute stalls three cycles with a valid pair on the lanes.
    iss_ready = 1'b0;
    send_pair(1, 32'h1111_0001, 32'h1111_0002, 3, 4, 5, 0, 0, 0, 0, 0);
    fork
      send_pair(1, 32'h2222_0001, 32'h2222_0002, 6, 7, 8, 0, 0, 0, 0, 0);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("t4_stall_in_ready", 64'(in_ready), 64'd0);
          check("t4_stall_iss0", {31'd0, iss0_valid, iss0_insn}, {32'd1, 32'h1111_0001});
          check("t4_stall_iss1", {31'd0, iss1_valid, iss1_insn}, {32'd1, 32'h1111_0002});
        end
        @(posedge clk); #1;
        iss_ready = 1'b1;
      end
    join
    idle(3);

    // T5: flush while holding the second half; held instruction must never appear.
    send_pair(1, 32'h3333_0001, 32'h3333_0002, 5, 5, 0, 1, 0, 0, 0, 1);
    void'(exp_q.pop_back());
    flush = 1'b1;
    @(negedge clk);
    check("t5_in_ready_flush", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t5_iss0_valid", 64'(iss0_valid), 64'd0);
    check("t5_iss1_valid", 64'(iss1_valid), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_split_count_kept", 64'(split_count), 64'd3);
    idle(3);

    // T6: saturate the 4-bit counter (3 splits so far, 14 more -> 17 total).
    for (int k = 0; k < 14; k++) begin
      send_pair(1, 32'h4000_0000 + 32'(2 * k), 32'h4000_0001 + 32'(2 * k), 5, 0, 0,
                0, 1, 0, 1, 1);
      if (k == 11) check("t6_count_15", 64'(split_count), 64'hF);
    end
    check("t6_count_sat", 64'(split_count), 64'hF);
    idle(3);

    // Async reset mid-split.
    send_pair(1, 32'h5555_0001, 32'h5555_0002, 7, 7, 0, 1, 0, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    check("rst_iss0_valid", 64'(iss0_valid), 64'd0);
    check("rst_iss1_valid", 64'(iss1_valid), 64'd0);
    check("rst_iss0_insn", 64'(iss0_insn), 64'd0);
    check("rst_split_count", 64'(split_count), 64'd0);
    exp_q.delete();
    idle(1);
    rst_n = 1'b1;
    idle(3);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_iss0_valid", 64'(iss0_valid), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
